// File: rtl/dmem_arb.sv
// Two-port arbiter in front of a single-port data memory: CPU port 0, loader/debug port 1.
// Round-robin on ties. Define DMEM_ARB_LOCK_EN to let port 1 hold the grant for up to MAX_BURST accesses.
module dmem_arb #(
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              wen0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  input  logic              req1,
  input  logic              wen1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  input  logic              lock1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              owner,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t state;
  logic   last_owner;
  logic   gnt0;
  logic   gnt1;
  logic   hold1;

`ifdef DMEM_ARB_LOCK_EN
  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

  logic [3:0] burst;

  // Counts consecutive acked port-1 accesses; any other cycle restarts the run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst <= 4'd0;
    end else if (state == GNT1 && req1) begin
      burst <= (burst == 4'hF) ? burst : burst + 4'd1;
    end else begin
      burst <= 4'd0;
    end
  end

  assign hold1 = lock1 & req1 & (burst < BURST_LAST);
`else
  logic unused_cfg;

  assign unused_cfg = lock1 ^ (MAX_BURST > 0);
  assign hold1      = 1'b0;
`endif

  // Arbitration FSM; last_owner records the port of the most recent acked access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_owner <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req0 && req1) begin
            state <= last_owner ? GNT0 : GNT1;
          end else if (req0) begin
            state <= GNT0;
          end else if (req1) begin
            state <= GNT1;
          end else begin
            state <= IDLE;
          end
        end
        GNT0: begin
          last_owner <= req0 ? 1'b0 : last_owner;
          if (req1) begin
            state <= GNT1;
          end else if (req0) begin
            state <= GNT0;
          end else begin
            state <= IDLE;
          end
        end
        GNT1: begin
          last_owner <= req1 ? 1'b1 : last_owner;
          if (hold1) begin
            state <= GNT1;
          end else if (req0) begin
            state <= GNT0;
          end else if (req1) begin
            state <= GNT1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Grants are also gated by rst so an access in flight is killed the instant reset rises.
  assign gnt0 = (state == GNT0) & ~rst;
  assign gnt1 = (state == GNT1) & ~rst;

  assign ack0      = gnt0 & req0;
  assign ack1      = gnt1 & req1;
  assign mem_wen   = (gnt0 & req0 & wen0) | (gnt1 & req1 & wen1);
  assign mem_addr  = gnt0 ? addr0  : (gnt1 ? addr1  : {ADDR_W{1'b0}});
  assign mem_wdata = gnt0 ? wdata0 : (gnt1 ? wdata1 : {DATA_W{1'b0}});
  assign rdata     = mem_rdata;
  assign owner     = gnt1;
  assign busy      = (state != IDLE) & ~rst;

endmodule

// File: tb/tb_dmem_arb.sv
// Self-checking bench for dmem_arb: vector table plus burst-lock and reset-abort sequences.
module tb_dmem_arb;

  logic        clk;
  logic        rst;
  logic        req0, wen0, req1, wen1, lock1;
  logic [8:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        ack0, ack1, mem_wen, owner, busy;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata, rdata;

  logic [31:0] mem [0:511];
  logic        pl_en;
  logic [8:0]  pl_addr;
  logic [31:0] pl_data;

  int checks;
  int errors;

  dmem_arb dut (
    .clk(clk), .rst(rst),
    .req0(req0), .wen0(wen0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .wen1(wen1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
    .lock1(lock1), .rdata(rdata),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .owner(owner), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory model with a preload path used only while the arbiter is idle.
  always @(posedge clk) begin
    if (mem_wen) mem[mem_addr] <= mem_wdata;
    else if (pl_en) mem[pl_addr] <= pl_data;
  end
  assign mem_rdata = mem[mem_addr];

  typedef struct {
    logic r0, w0; logic [8:0] a0; logic [31:0] d0;
    logic r1, w1; logic [8:0] a1; logic [31:0] d1;
    logic e_ack0, e_ack1, e_wen, e_own, e_busy;
    logic [8:0] e_addr; logic [31:0] e_wdata;
    logic chk_rd; logic [31:0] e_rdata;
  } vec_t;

  localparam int NV = 20;
  vec_t tv [NV];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  initial begin
    logic [1:0] exp2;
    checks = 0; errors = 0;
    rst = 1'b1; lock1 = 1'b0;
    req0 = 1'b0; wen0 = 1'b0; addr0 = 9'h000; wdata0 = 32'h0;
    req1 = 1'b0; wen1 = 1'b0; addr1 = 9'h000; wdata1 = 32'h0;
    pl_en = 1'b1; pl_addr = 9'h000; pl_data = 32'h12345678;

    //         r0   w0   a0      d0            r1   w1   a1      d1            ack0 ack1 wen  own  busy addr    wdata         chk  rdata
    tv[0]  = '{1'b0,1'b0,9'h000,32'h0,        1'b0,1'b0,9'h000,32'h0,        1'b0,1'b0,1'b0,1'b0,1'b0,9'h000,32'h0,        1'b1,32'h12345678};
    tv[1]  = '{1'b1,1'b1,9'h004,32'hDEADBEEF, 1'b0,1'b0,9'h000,32'h0,        1'b0,1'b0,1'b0,1'b0,1'b0,9'h000,32'h0,        1'b1,32'h12345678};
    tv[2]  = '{1'b1,1'b1,9'h004,32'hDEADBEEF, 1'b0,1'b0,9'h000,32'h0,        1'b1,1'b0,1'b1,1'b0,1'b1,9'h004,32'hDEADBEEF, 1'b0,32'h0};
    tv[3]  = '{1'b0,1'b0,9'h004,32'h0,        1'b1,1'b0,9'h004,32'h0,        1'b0,1'b0,1'b0,1'b0,1'b1,9'h004,32'h0,        1'b1,32'hDEADBEEF};
    tv[4]  = '{1'b0,1'b0,9'h004,32'h0,        1'b1,1'b0,9'h004,32'h0,        1'b0,1'b1,1'b0,1'b1,1'b1,9'h004,32'h0,        1'b1,32'hDEADBEEF};
    tv[5]  = '{1'b0,1'b0,9'h000,32'h0,        1'b0,1'b0,9'h004,32'h0,        1'b0,1'b0,1'b0,1'b1,1'b1,9'h004,32'h0,        1'b1,32'hDEADBEEF};
    tv[6]  = '{1'b0,1'b0,9'h000,32'h0,        1'b0,1'b0,9'h000,32'h0,        1'b0,1'b0,1'b0,1'b0,1'b0,9'h000,32'h0,        1'b1,32'h12345678};
    tv[7]  = '{1'b1,1'b0,9'h004,32'h0,        1'b1,1'b0,9'h004,32'h0,        1'b0,1'b0,1'b0,1'b0,1'b0,9'h000,32'h0,        1'b1,32'h12345678};
    tv[8]  = '{1'b1,1'b0,9'h004,32'h0,        1'b1,1'b0,9'h004,32'h0,        1'b1,1'b0,1'b0,1'b0,1'b1,9'h004,32'h0,        1'b1,32'hDEADBEEF};
    tv[9]  = '{1'b1,1'b0,9'h004,32'h0,        1'b1,1'b0,9'h004,32'h0,        1'b0,1'b1,1'b0,1'b1,1'b1,9'h004,32'h0,        1'b1,32'hDEADBEEF};
    tv[10] = '{1'b1,1'b0,9'h004,32'h0,        1'b1,1'b0,9'h004,32'h0,        1'b1,1'b0,1'b0,1'b0,1'b1,9'h004,32'h0,        1'b1,32'hDEADBEEF};
    tv[11] = '{1'b0,1'b0,9'h000,32'h0,        1'b0,1'b0,9'h000,32'h0,        1'b0,1'b0,1'b0,1'b1,1'b1,9'h000,32'h0,        1'b1,32'h12345678};
    tv[12] = '{1'b0,1'b0,9'h000,32'h0,        1'b1,1'b1,9'h008,32'hCAFEF00D, 1'b0,1'b0,1'b0,1'b0,1'b0,9'h000,32'h0,        1'b1,32'h12345678};
    tv[13] = '{1'b0,1'b0,9'h000,32'h0,        1'b1,1'b1,9'h008,32'hCAFEF00D, 1'b0,1'b1,1'b1,1'b1,1'b1,9'h008,32'hCAFEF00D, 1'b0,32'h0};
    tv[14] = '{1'b0,1'b0,9'h000,32'h0,        1'b0,1'b0,9'h008,32'h0,        1'b0,1'b0,1'b0,1'b1,1'b1,9'h008,32'h0,        1'b1,32'hCAFEF00D};
    tv[15] = '{1'b0,1'b0,9'h000,32'h0,        1'b0,1'b0,9'h000,32'h0,        1'b0,1'b0,1'b0,1'b0,1'b0,9'h000,32'h0,        1'b1,32'h12345678};
    tv[16] = '{1'b1,1'b0,9'h008,32'h0,        1'b0,1'b0,9'h000,32'h0,        1'b0,1'b0,1'b0,1'b0,1'b0,9'h000,32'h0,        1'b1,32'h12345678};
    tv[17] = '{1'b1,1'b0,9'h008,32'h0,        1'b0,1'b0,9'h000,32'h0,        1'b1,1'b0,1'b0,1'b0,1'b1,9'h008,32'h0,        1'b1,32'hCAFEF00D};
    tv[18] = '{1'b0,1'b0,9'h000,32'h0,        1'b0,1'b0,9'h000,32'h0,        1'b0,1'b0,1'b0,1'b0,1'b1,9'h000,32'h0,        1'b1,32'h12345678};
    tv[19] = '{1'b0,1'b0,9'h000,32'h0,        1'b0,1'b0,9'h000,32'h0,        1'b0,1'b0,1'b0,1'b0,1'b0,9'h000,32'h0,        1'b1,32'h12345678};

    // Preload words 0x000 and 0x010 while reset holds the arbiter idle.
    @(posedge clk); #1; pl_addr = 9'h010; pl_data = 32'h00005A5A;
    @(posedge clk); #1; pl_en = 1'b0;
    @(negedge clk);
    chk("reset_outs", {17'd0, ack0, ack1, mem_wen, owner, busy, mem_addr, mem_wdata},
        {17'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 32'h0});
    chk("reset_rdata", {32'd0, rdata}, {32'd0, 32'h12345678});
    @(posedge clk); #1; rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      req0 = tv[i].r0; wen0 = tv[i].w0; addr0 = tv[i].a0; wdata0 = tv[i].d0;
      req1 = tv[i].r1; wen1 = tv[i].w1; addr1 = tv[i].a1; wdata1 = tv[i].d1;
      @(negedge clk);
      chk($sformatf("vec%0d", i), {18'd0, ack0, ack1, mem_wen, owner, busy, mem_addr, mem_wdata},
          {18'd0, tv[i].e_ack0, tv[i].e_ack1, tv[i].e_wen, tv[i].e_own, tv[i].e_busy, tv[i].e_addr, tv[i].e_wdata});
      if (tv[i].chk_rd)
        chk($sformatf("vec%0d_rdata", i), {32'd0, rdata}, {32'd0, tv[i].e_rdata});
    end
    chk("mem4", {32'd0, mem[9'h004]}, {32'd0, 32'hDEADBEEF});

    // Both ports plus lock1 held from a fresh reset: grant pattern depends on the lock build.
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    req0 = 1'b1; wen0 = 1'b0; addr0 = 9'h004;
    req1 = 1'b1; wen1 = 1'b0; addr1 = 9'h008; lock1 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
`ifdef DMEM_ARB_LOCK_EN
      exp2 = (i == 0) ? 2'b00 : ((((i - 1) % 5) == 0) ? 2'b10 : 2'b01);
`else
      exp2 = (i == 0) ? 2'b00 : (((i % 2) == 1) ? 2'b10 : 2'b01);
`endif
      chk($sformatf("burst%0d", i), {62'd0, ack0, ack1}, {62'd0, exp2});
    end
    @(posedge clk); #1; req0 = 1'b0; req1 = 1'b0; lock1 = 1'b0;
    repeat (3) @(posedge clk);

    // Reset raised in the middle of a granted port-0 write.
    #1; req0 = 1'b1; wen0 = 1'b1; addr0 = 9'h020; wdata0 = 32'h7;
    @(negedge clk); chk("abort_idle", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
    @(negedge clk); chk("abort_first_ack", {63'd0, ack0}, 64'd1);
    @(posedge clk); #1; addr0 = 9'h010; wdata0 = 32'h1;
    #2; chk("abort_pre", {62'd0, ack0, mem_wen}, {62'd0, 2'b11});
    rst = 1'b1;
    #1; chk("abort_drop", {61'd0, ack0, mem_wen, busy}, {61'd0, 3'b000});
    @(posedge clk); #1; req0 = 1'b0; wen0 = 1'b0; addr0 = 9'h000; wdata0 = 32'h0;
    @(posedge clk); #1; rst = 1'b0;
    req0 = 1'b1; req1 = 1'b1; addr1 = 9'h000;
    @(negedge clk); chk("tie_idle", {62'd0, ack0, ack1}, {62'd0, 2'b00});
    @(negedge clk); chk("tie_port0", {62'd0, ack0, ack1}, {62'd0, 2'b10});
    chk("mem10_kept", {32'd0, mem[9'h010]}, {32'd0, 32'h00005A5A});
    chk("mem20", {32'd0, mem[9'h020]}, {32'd0, 32'h7});
    @(posedge clk); #1; req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arb.md
DMEM_ARB -- requirements
Module: dmem_arb

Interface
REQ-001 Parameter ADDR_W, default 9, data-memory word-address width.
REQ-002 Parameter DATA_W, default 32, data width.
REQ-003 Parameter MAX_BURST, default 4, max consecutive locked grants to port 1; legal range 1..15.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 req0  input  1  CPU port request.
REQ-007 wen0  input  1  CPU port write enable (0 = read).
REQ-008 addr0  input  ADDR_W  CPU port word address.
REQ-009 wdata0  input  DATA_W  CPU port write data.
REQ-010 ack0  output  1  CPU port access-complete pulse.
REQ-011 req1 / wen1 / addr1 / wdata1 / ack1: same widths and meanings, loader/debug port.
REQ-012 lock1  input  1  port 1 requests to keep the grant across consecutive accesses.
REQ-013 rdata  output  DATA_W  read data, combinational copy of mem_rdata, shared by both ports.
REQ-014 mem_addr  output  ADDR_W;  mem_wen  output  1;  mem_wdata  output  DATA_W: drive the DATAMEM port.
REQ-015 mem_rdata  input  DATA_W  combinational read data from DATAMEM.
REQ-016 owner  output  1  port currently granted; busy  output  1  high in any grant state.

Function
REQ-017 States: IDLE, GNT0, GNT1; state is registered, so an access always takes one full cycle in a GNT state.
REQ-018 Requester SHALL hold req, wen, addr and wdata stable from assertion until the cycle ackX is high.
REQ-019 In GNTx: mem_addr/mem_wdata = port x inputs, mem_wen = wenx & reqx, ackx = reqx; write commits on the clock edge ending that cycle; rdata valid during that cycle.
REQ-020 Outside GNT states: mem_wen = 0, mem_addr = 0, mem_wdata = 0, ack0 = ack1 = 0.
REQ-021 Latency: req seen in IDLE at cycle N -> GNT entered at N+1, ackx high during N+1.
REQ-022 Next-state from IDLE: only one req -> that port; both -> port not equal to last_owner (round-robin pointer).
REQ-023 Next-state from GNTx (after ack): other port requesting -> GNT of other port; else own req still high -> stay GNTx (back-to-back, one access per cycle); else IDLE.
REQ-024 last_owner SHALL update to x on every cycle spent in GNTx with ackx high.
REQ-025 Port withdrawing req while in its GNT state (protocol violation): no ack, mem_wen 0, next state per REQ-023 with own req = 0.
REQ-026 busy = (state != IDLE); owner = 1 only in GNT1, else 0.
REQ-027 Burst counter (4 bits) counts consecutive acked port-1 accesses; cleared on any cycle not in GNT1.

Reset
REQ-028 While rst high: state IDLE, last_owner = 1 (port 0 wins first tie), burst counter 0, all outputs 0 except rdata (follows mem_rdata).
REQ-029 rst asserted mid-access: ack and mem_wen drop immediately (asynchronously); no write commits; that access is not completed and must be re-requested.

Configuration
REQ-030 Macro DMEM_ARB_LOCK_EN defined: in GNT1 with lock1 & req1 and burst counter < MAX_BURST-1, port 1 keeps the grant even if req0 high; on reaching MAX_BURST acks, SHALL move to GNT0 if req0 high.
REQ-031 Macro DMEM_ARB_LOCK_EN undefined: lock1 ignored, counter absent, REQ-023 alone applies.

Verification
REQ-032 Reset release, req0=1, wen0=1, addr0=9'h004, wdata0=32'hDEADBEEF -> ack0 in cycle 1 after req, mem_wen=1, memory word 4 = DEADBEEF.
REQ-033 req0 and req1 both rise in IDLE after reset -> GNT0 first, then GNT1 next cycle, then alternate while both held (ack0, ack1, ack0, ...).
REQ-034 Read: req1=1, wen1=0, addr1=9'h004 -> ack1 cycle with rdata=32'hDEADBEEF, mem_wen=0.
REQ-035 With DMEM_ARB_LOCK_EN, MAX_BURST=4, req0, req1, lock1 all held, port 1 granted -> exactly 4 consecutive ack1, then ack0; without macro -> strict alternation.
REQ-036 rst pulsed during GNT0 with wen0=1, addr0=9'h010, wdata0=32'h1 -> ack0 and mem_wen fall same cycle, word 0x010 unchanged, state IDLE, next tie goes to port 0.
